decode_sel_stage: RTL

//  Fetch->decode pipeline stage directly upstream of the immediate generator.

---
 rtl/decode_sel_stage.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/decode_sel_stage.sv
// Fetch->decode stage: 2-entry skid buffer with opcode -> imm_sel decode for immGen.
// Optional ILLEGAL_OPCODE_EN adds out_illegal, flagging opcodes outside the supported set.
module decode_sel_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned SEL_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_inst,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_pc,
  output logic [XLEN-1:0]  out_inst,
  output logic [SEL_W-1:0] out_imm_sel
`ifdef ILLEGAL_OPCODE_EN
  ,
  output logic             out_illegal
`endif
);

  localparam logic [SEL_W-1:0] SelR     = SEL_W'(0);
  localparam logic [SEL_W-1:0] SelS     = SEL_W'(1);
  localparam logic [SEL_W-1:0] SelB     = SEL_W'(2);
  localparam logic [SEL_W-1:0] SelU     = SEL_W'(3);
  localparam logic [SEL_W-1:0] SelJ     = SEL_W'(4);
  localparam logic [SEL_W-1:0] SelI     = SEL_W'(5);
  localparam logic [SEL_W-1:0] SelIStar = SEL_W'(6);

  localparam logic [XLEN-1:0] Nop = XLEN'(32'h0000_0013);

  typedef struct packed {
    logic [XLEN-1:0]  pc;
    logic [XLEN-1:0]  inst;
    logic [SEL_W-1:0] sel;
  } entry_t;

  localparam entry_t EntryRst = '{pc: '0, inst: Nop, sel: SelI};

  entry_t head_q, skid_q, in_entry, head_d;
  logic   head_valid_q, head_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   head_we, head_from_skid, skid_we;
  logic   accept, consume;
  logic [SEL_W-1:0] in_sel;

`ifdef ILLEGAL_OPCODE_EN
  logic in_illegal, head_ill_q, skid_ill_q, head_ill_d;
`endif

  // Opcode decode on the incoming word, before it is registered.
  always_comb begin
    in_sel = SelR;
`ifdef ILLEGAL_OPCODE_EN
    in_illegal = 1'b0;
`endif
    case (in_inst[6:0])
      7'b0110011: in_sel = SelR;
      7'b0100011: in_sel = SelS;
      7'b1100011: in_sel = SelB;
      7'b0110111,
      7'b0010111: in_sel = SelU;
      7'b1101111: in_sel = SelJ;
      7'b0000011,
      7'b1100111,
      7'b1110011: in_sel = SelI;
      7'b0010011: begin
        if (in_inst[14:12] == 3'b001 || in_inst[14:12] == 3'b101) begin
          in_sel = SelIStar;
        end else begin
          in_sel = SelI;
        end
      end
      default: begin
        in_sel = SelR;
`ifdef ILLEGAL_OPCODE_EN
        in_illegal = 1'b1;
`endif
      end
    endcase
  end

  assign in_entry = '{pc: in_pc, inst: in_inst, sel: in_sel};

  assign in_ready = ~skid_valid_q;
  assign accept   = in_valid & in_ready;
  assign consume  = head_valid_q & out_ready;

  always_comb begin
    head_valid_d   = head_valid_q;
    skid_valid_d   = skid_valid_q;
    head_we        = 1'b0;
    head_from_skid = 1'b0;
    skid_we        = 1'b0;
    if (flush) begin
      // Redirect: drop everything, including a same-cycle accept.
      head_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (!head_valid_q) begin
      if (accept) begin
        head_valid_d = 1'b1;
        head_we      = 1'b1;
      end
    end else if (consume) begin
      if (skid_valid_q) begin
        head_we        = 1'b1;
        head_from_skid = 1'b1;
        skid_valid_d   = accept;
        skid_we        = accept;
      end else if (accept) begin
        head_we = 1'b1;
      end else begin
        head_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_we      = 1'b1;
      skid_valid_d = 1'b1;
    end
  end

  assign head_d = head_from_skid ? skid_q : in_entry;
`ifdef ILLEGAL_OPCODE_EN
  assign head_ill_d = head_from_skid ? skid_ill_q : in_illegal;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q       <= EntryRst;
      skid_q       <= EntryRst;
      head_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      head_valid_q <= head_valid_d;
      skid_valid_q <= skid_valid_d;
      if (head_we) head_q <= head_d;
      if (skid_we) skid_q <= in_entry;
    end
  end

`ifdef ILLEGAL_OPCODE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_ill_q <= 1'b0;
      skid_ill_q <= 1'b0;
    end else begin
      if (head_we) head_ill_q <= head_ill_d;
      if (skid_we) skid_ill_q <= in_illegal;
    end
  end

  assign out_illegal = head_ill_q;
`endif

  assign out_valid   = head_valid_q;
  assign out_pc      = head_q.pc;
  assign out_inst    = head_q.inst;
  assign out_imm_sel = head_q.sel;

endmodule
